// File: rtl/pipeline_pkg.sv
// Shared instruction-format definitions for the issue controller and instr_decode.
package pipeline_pkg;

    // Instruction type field values
    localparam logic [1:0] INSTR_NOP   = 2'b00;
    localparam logic [1:0] INSTR_ARITH = 2'b01;
    localparam logic [1:0] INSTR_MEM   = 2'b10;
    localparam logic [1:0] INSTR_AUDIO = 2'b11;

    // Op codes with special meaning
    localparam logic [2:0] MOVE_LO  = 3'b101;
    localparam logic [2:0] MOVE_HI  = 3'b110;
    localparam logic [2:0] MOVE_REG = 3'b111;
    localparam logic [2:0] LOAD_LO  = 3'b001;
    localparam logic [2:0] LOAD_HI  = 3'b010;

    // Field positions; rd and rs1 share one field
    localparam int IMM_BIT = 31;
    localparam int TYPE_HI = 30;
    localparam int TYPE_LO = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 26;
    localparam int RD_HI   = 21;
    localparam int RD_LO   = 19;
    localparam int RS2_HI  = 18;
    localparam int RS2_LO  = 16;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ARITH,
        CLS_MOVE,
        CLS_MEM,
        CLS_AUDIO
    } instr_class_t;

    typedef struct packed {
        logic valid;
        logic writes_rd;
        logic reads_rs1;
        logic reads_rs2;
        logic is_audio;
    } instr_info_t;

    // Class of an instruction from its type and op fields
    function automatic instr_class_t instr_class(input logic [1:0] ty, input logic [2:0] op);
        instr_class_t c;
        case (ty)
            INSTR_NOP:   c = CLS_NOP;
            INSTR_ARITH: c = (op == MOVE_LO || op == MOVE_HI || op == MOVE_REG) ? CLS_MOVE : CLS_ARITH;
            INSTR_MEM:   c = CLS_MEM;
            default:     c = CLS_AUDIO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational instruction classifier: register usage summary for one instruction.
module instr_classify
    import pipeline_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output instr_info_t  info
);

    logic [1:0] ty;
    logic [2:0] op;
    logic       imm;
    logic       unused_bits;

    assign unused_bits = ^{instr[25:22], instr[15:0], instr[RD_HI:RS2_LO]};

    // Decode class and which register ports the instruction touches
    always_comb begin
        ty   = instr[TYPE_HI:TYPE_LO];
        op   = instr[OP_HI:OP_LO];
        imm  = instr[IMM_BIT];
        cls  = instr_class(ty, op);
        info = '0;
        info.valid     = (cls != CLS_NOP);
        info.is_audio  = (cls == CLS_AUDIO);
        info.writes_rd = (cls == CLS_ARITH) || (cls == CLS_MOVE) ||
                         ((cls == CLS_MEM) && (op == LOAD_LO || op == LOAD_HI));
        info.reads_rs1 = (cls == CLS_ARITH) || (cls == CLS_MEM) || (cls == CLS_AUDIO);
        info.reads_rs2 = !imm && ((cls == CLS_ARITH) || (cls == CLS_AUDIO) ||
                                  ((cls == CLS_MOVE) && (op == MOVE_REG)) ||
                                  ((cls == CLS_MEM) && op[2]));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Issue controller: writeback scoreboard, audio busy timer, stall generation
// and a saturating stall-cycle counter for the debug display.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int WB_LATENCY = 3,
    parameter int AUDIO_BUSY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_id_instr,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [2:0]       hazard_reg,
    output logic             audio_stall,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int PW = $clog2(WB_LATENCY + 1);
    localparam int AW = $clog2(AUDIO_BUSY + 1);

    instr_class_t    cls;
    instr_info_t     info;
    logic [2:0]      rd;
    logic [2:0]      rs2;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            rd_hit;
    logic            hazard;

    logic [PW-1:0]    pend_q [8];
    logic [PW-1:0]    pend_d [8];
    logic [AW-1:0]    abusy_q;
    logic [AW-1:0]    abusy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             unused_cls;

    instr_classify u_classify (
        .instr (if_id_instr),
        .cls   (cls),
        .info  (info)
    );

    assign unused_cls   = ^cls;
    assign stall_cycles = cnt_q;

    // Hazard detection and stall/issue outputs, purely from registered state and IF/ID
    always_comb begin
        rd      = if_id_instr[RD_HI:RD_LO];
        rs2     = if_id_instr[RS2_HI:RS2_LO];
        rs1_hit = info.reads_rs1 && (pend_q[rd] != '0);
        rs2_hit = info.reads_rs2 && (pend_q[rs2] != '0);
        rd_hit  = info.writes_rd && (pend_q[rd] != '0);
        hazard  = info.valid && (rs1_hit || rs2_hit || rd_hit);
        hazard_reg = 3'd0;
        if (hazard) begin
            if (rs1_hit)      hazard_reg = rd;
            else if (rs2_hit) hazard_reg = rs2;
            else              hazard_reg = rd;
        end
        audio_stall = info.valid && info.is_audio && (abusy_q != '0);
        stall       = !flush && (hazard || audio_stall);
        issue       = !flush && !stall && info.valid;
    end

    // Next state: a new write reloads its register's counter, otherwise counters drain
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            if (issue && info.writes_rd && (rd == 3'(r))) pend_d[r] = PW'(WB_LATENCY);
            else if (pend_q[r] != '0)                     pend_d[r] = pend_q[r] - PW'(1);
            else                                          pend_d[r] = pend_q[r];
        end
        if (issue && info.is_audio) abusy_d = AW'(AUDIO_BUSY);
        else if (abusy_q != '0)     abusy_d = abusy_q - AW'(1);
        else                        abusy_d = abusy_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        else                        cnt_d = cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) pend_q[r] <= '0;
            abusy_q <= '0;
            cnt_q   <= '0;
        end else begin
            for (int r = 0; r < 8; r++) pend_q[r] <= pend_d[r];
            abusy_q <= abusy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a
// model that tracks, per register, the cycle at which its pending write commits.
module tb_pipeline_hazard_ctrl;

    localparam int WB = 3;
    localparam int AB = 4;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   if_id_instr = '0;
    logic          flush = 1'b0;
    logic          stall, issue, audio_stall;
    logic [2:0]    hazard_reg;
    logic [15:0]   stall_cycles;
    logic          s_stall, s_issue, s_audio;
    logic [2:0]    s_hreg;
    logic [SW-1:0] s_cycles;

    // Clock
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WB_LATENCY(WB), .AUDIO_BUSY(AB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .flush(flush),
        .stall(stall), .issue(issue), .hazard_reg(hazard_reg),
        .audio_stall(audio_stall), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    pipeline_hazard_ctrl #(.WB_LATENCY(WB), .AUDIO_BUSY(AB), .CNT_W(SW)) sat_dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .flush(flush),
        .stall(s_stall), .issue(s_issue), .hazard_reg(s_hreg),
        .audio_stall(s_audio), .stall_cycles(s_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: commit cycles rather than down-counters
    int   cyc = 0;
    int   ready_at [8];
    int   audio_free = 0;
    int   cnt = 0;
    bit   e_stall, e_issue, e_audio;
    bit [2:0] e_hreg;
    bit   m_wr, m_au;
    int   m_rd;
    int   obs_stalls;
    logic last_issue;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] mk(input bit imm, input bit [1:0] ty, input bit [2:0] op,
                                       input bit [2:0] rd, input bit [2:0] rs2);
        logic [31:0] v;
        v = '0;
        v[31] = imm;
        v[30:29] = ty;
        v[28:26] = op;
        v[21:19] = rd;
        v[18:16] = rs2;
        return v;
    endfunction

    // Register usage from the instruction class rules
    task automatic classify(input logic [31:0] ins, output bit vl, output bit wr,
                            output bit r1, output bit r2, output bit au);
        bit [1:0] ty;
        bit [2:0] op;
        bit       imm;
        ty = ins[30:29];
        op = ins[28:26];
        imm = ins[31];
        vl = (ty != 0);
        wr = 0; r1 = 0; r2 = 0; au = 0;
        case (ty)
            2'd1: begin
                wr = 1;
                if (op >= 5) r2 = (op == 7) && !imm;
                else begin r1 = 1; r2 = !imm; end
            end
            2'd2: begin r1 = 1; wr = (op == 1 || op == 2); r2 = op[2] && !imm; end
            2'd3: begin au = 1; r1 = 1; r2 = !imm; end
            default: ;
        endcase
    endtask

    task automatic model_eval();
        bit vl, wr, r1, r2, au, h1, h2, h3;
        int a, b;
        classify(if_id_instr, vl, wr, r1, r2, au);
        a = int'(if_id_instr[21:19]);
        b = int'(if_id_instr[18:16]);
        h1 = r1 && (cyc < ready_at[a]);
        h2 = r2 && (cyc < ready_at[b]);
        h3 = wr && (cyc < ready_at[a]);
        e_hreg  = h1 ? 3'(a) : h2 ? 3'(b) : h3 ? 3'(a) : 3'd0;
        e_audio = au && (cyc < audio_free);
        e_stall = !flush && (h1 || h2 || h3 || e_audio);
        e_issue = !flush && !e_stall && vl;
        m_wr = wr;
        m_au = au;
        m_rd = a;
    endtask

    task automatic model_commit();
        if (e_issue && m_wr) ready_at[m_rd] = cyc + WB + 1;
        if (e_issue && m_au) audio_free = cyc + AB + 1;
        if (e_stall) cnt++;
        cyc++;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) ready_at[r] = 0;
        audio_free = 0;
        cnt = 0;
    endtask

    // One cycle: apply inputs, compare at negedge, advance model at posedge
    task automatic drive(input logic [31:0] ins, input logic fl);
        if_id_instr = ins;
        flush = fl;
        @(negedge clk);
        model_eval();
        check("stall", 32'(stall), 32'(e_stall));
        check("issue", 32'(issue), 32'(e_issue));
        check("hazard_reg", 32'(hazard_reg), 32'(e_hreg));
        check("audio_stall", 32'(audio_stall), 32'(e_audio));
        check("stall_cycles", 32'(stall_cycles), (cnt > 65535) ? 32'd65535 : 32'(cnt));
        check("sat_stall", 32'(s_stall), 32'(e_stall));
        check("sat_cycles", 32'(s_cycles), (cnt > 63) ? 32'd63 : 32'(cnt));
        obs_stalls += int'(stall);
        last_issue = issue;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset(input logic [31:0] ins);
        reset = 1'b1;
        if_id_instr = ins;
        flush = 1'b0;
        @(posedge clk);
        model_reset();
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    // Hold an instruction in IF/ID until it issues; stalls seen are left in obs_stalls
    task automatic issue_until(input logic [31:0] ins);
        obs_stalls = 0;
        for (int i = 0; i < 20; i++) begin
            drive(ins, 1'b0);
            if (e_issue) break;
            if (i == 19) check("issue_timeout", 32'(0), 32'(1));
        end
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] dep;
        bit          fl;
        model_reset();

        // Reset state with a nop in IF/ID
        do_reset('0);
        drive('0, 1'b0);

        // RAW on r1: three stall cycles
        issue_until(mk(0, 2'd1, 3'd0, 3'd1, 3'd3));
        issue_until(mk(0, 2'd1, 3'd0, 3'd1, 3'd5));
        check("t1_stalls", 32'(obs_stalls), 32'd3);
        check("t1_cnt", 32'(stall_cycles), 32'd3);

        // MOVE_LO r2 then immediate arith not touching r2: back-to-back issue
        do_reset('0);
        issue_until(mk(1, 2'd1, 3'b101, 3'd2, 3'd0));
        issue_until(mk(1, 2'd1, 3'd0, 3'd6, 3'd7));
        check("t2_stalls", 32'(obs_stalls), 32'd0);

        // Audio back-to-back: four stall cycles
        issue_until(mk(0, 2'd3, 3'd0, 3'd4, 3'd5));
        issue_until(mk(0, 2'd3, 3'd0, 3'd4, 3'd5));
        check("t3_stalls", 32'(obs_stalls), 32'd4);

        // WAW via LOAD_HI/LOAD_LO on r3, then a reader of r3 sees the reload
        do_reset('0);
        issue_until(mk(0, 2'd2, 3'b010, 3'd3, 3'd0));
        issue_until(mk(0, 2'd2, 3'b001, 3'd3, 3'd0));
        check("t4_stalls", 32'(obs_stalls), 32'd3);
        issue_until(mk(0, 2'd1, 3'd0, 3'd3, 3'd0));
        check("t4_reload_stalls", 32'(obs_stalls), 32'd3);

        // Flush during a hazard stall, then a nop
        do_reset('0);
        dep = mk(0, 2'd1, 3'd0, 3'd1, 3'd2);
        issue_until(mk(0, 2'd1, 3'd0, 3'd1, 3'd0));
        drive(dep, 1'b0);
        drive(dep, 1'b1);
        drive('0, 1'b0);

        // Reset mid-stall: the held instruction issues immediately afterwards
        issue_until(mk(0, 2'd1, 3'd0, 3'd1, 3'd0));
        drive(dep, 1'b0);
        do_reset(dep);
        drive(dep, 1'b0);
        check("t5_rst_issue", 32'(last_issue), 32'd1);

        // Random traffic, new instruction only when the previous one left IF/ID
        do_reset('0);
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!e_stall || flush) begin
                cur = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                         3'($urandom_range(0, 3)));
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(cur, fl);
        end

        // Drive the narrow counter into saturation, then clear it with reset
        do_reset('0);
        for (int i = 0; i < 25; i++) issue_until(mk(0, 2'd3, 3'd1, 3'd0, 3'd0));
        check("sat_hold", 32'(s_cycles), 32'd63);
        check("wide_count", 32'(stall_cycles), 32'd96);
        do_reset('0);
        check("sat_after_reset", 32'(s_cycles), 32'd0);
        check("wide_after_reset", 32'(stall_cycles), 32'd0);
        drive('0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
